// File: rtl/ft245_tx.sv
// Drains a first-word-fall-through FIFO into an FT245 asynchronous USB FIFO.
// Each byte is popped once and written with programmable setup/strobe/hold/gap timing.
module ft245_tx #(
  parameter int data_width   = 8,
  parameter int setup_cycles = 1,
  parameter int wr_cycles    = 2,
  parameter int hold_cycles  = 1,
  parameter int gap_cycles   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [data_width-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  fifo_rinc,
  input  logic                  ft_txe_n,
  output logic [data_width-1:0] ft_data,
  output logic                  ft_data_oe,
  output logic                  ft_wr_n,
  output logic                  busy,
  output logic [31:0]           byte_count,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LD = CW'(setup_cycles - 1);
  localparam logic [CW-1:0] WR_LD    = CW'(wr_cycles - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(hold_cycles - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(gap_cycles - 1);

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [1:0]            txe_sync;
  logic                  txe_s;
  logic [data_width-1:0] data_d;
  logic                  oe_d, wr_n_d, rinc_d, busy_d;
  logic [31:0]           count_d;

  assign txe_s     = txe_sync[1];
  assign state_dbg = state;

  // FIFO handshake: fifo_rempty=0 means fifo_rdata is valid; a one-cycle
  // fifo_rinc consumes that word. Both are only looked at in IDLE.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = ft_data;
    rinc_d  = 1'b0;
    count_d = byte_count;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_rempty && !txe_s) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          data_d  = fifo_rdata;
          rinc_d  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_d = STROBE;
          cnt_d   = WR_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          count_d = byte_count + 32'd1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Bus outputs are decoded from the next state so they register cleanly.
    oe_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    wr_n_d = (state_d != STROBE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      txe_sync   <= 2'b11;
      fifo_rinc  <= 1'b0;
      ft_data    <= '0;
      ft_data_oe <= 1'b0;
      ft_wr_n    <= 1'b1;
      busy       <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      txe_sync   <= {txe_sync[0], ft_txe_n};
      fifo_rinc  <= rinc_d;
      ft_data    <= data_d;
      ft_data_oe <= oe_d;
      ft_wr_n    <= wr_n_d;
      busy       <= busy_d;
      byte_count <= count_d;
    end
  end

endmodule

// File: tb/tb_ft245_tx.sv
// Bench for ft245_tx: FIFO queue model, per-cycle timeline model of the bus,
// and directed scenarios with hand-computed expectations.
module tb_ft245_tx;

  localparam int S = 1, W = 2, H = 1, G = 3;
  localparam int TOT = S + W + H + G;

  // clock/reset block
  logic clk = 1'b0;
  logic rst, tx_en, ft_txe_n;
  logic [7:0] fifo_rdata;
  logic fifo_rempty;
  logic fifo_rinc, ft_data_oe, ft_wr_n, busy;
  logic [7:0] ft_data;
  logic [31:0] byte_count;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  ft245_tx #(.data_width(8), .setup_cycles(S), .wr_cycles(W), .hold_cycles(H), .gap_cycles(G)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc), .ft_txe_n(ft_txe_n), .ft_data(ft_data), .ft_data_oe(ft_data_oe),
    .ft_wr_n(ft_wr_n), .busy(busy), .byte_count(byte_count), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO model: expected queue of words waiting to be sent
  logic [7:0] exp_q[$];

  task automatic refresh();
    fifo_rempty = (exp_q.size() == 0);
    fifo_rdata  = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
    refresh();
  endtask

  // driver: advance one cycle, inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (fifo_rinc) begin
      chk("pop_when_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      refresh();
    end
  endtask

  // timeline model: t = position inside a transfer (0 = idle, 1 = first SETUP cycle)
  int t = 0;
  logic [7:0] m_data = 8'h00;
  logic [31:0] m_count = 32'd0;
  logic h1 = 1'b1, h2 = 1'b1;
  bit m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_data = 8'h00; m_count = 32'd0; h1 = 1'b1; h2 = 1'b1; m_live = 1'b1;
    end else begin
      if (t == 0) begin
        if (tx_en && !fifo_rempty && !h2) begin
          t = 1;
          m_data = fifo_rdata;
        end
      end else begin
        if (t == S + W) m_count = m_count + 32'd1;
        t = (t == TOT) ? 0 : t + 1;
      end
      h2 = h1;
      h1 = ft_txe_n;
    end
  end

  // scoreboard compare + bus monitor
  int cyc = 0, rinc_n = 0, oe_n = 0, wrlow_n = 0;
  int strobe_cyc[$];
  logic [7:0] strobe_dat[$];
  logic prev_wr = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      chk("rinc", fifo_rinc, (t == 1));
      chk("oe", ft_data_oe, (t >= 1 && t <= S + W + H));
      chk("wr_n", ft_wr_n, !(t > S && t <= S + W));
      chk("busy", busy, (t != 0));
      chk("data", ft_data, m_data);
      chk("count", byte_count, m_count);
    end
    if (fifo_rinc) rinc_n++;
    if (ft_data_oe) oe_n++;
    if (ft_wr_n === 1'b0) wrlow_n++;
    if (prev_wr === 1'b1 && ft_wr_n === 1'b0) begin
      strobe_cyc.push_back(cyc);
      strobe_dat.push_back(ft_data);
    end
    prev_wr = ft_wr_n;
  end

  initial begin
    int r0, o0, w0, s0, lat;
    bit found;
    logic [7:0] burst[4];
    burst = '{8'h01, 8'h02, 8'h0A, 8'h0B};
    rst = 1'b1; tx_en = 1'b1; ft_txe_n = 1'b0;
    refresh();
    push(8'hA5);

    // reset held with FIFO non-empty and TXE# low
    repeat (3) begin
      tick();
      chk("rst_wr_n", ft_wr_n, 1'b1);
      chk("rst_oe", ft_data_oe, 1'b0);
      chk("rst_rinc", fifo_rinc, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", byte_count, 32'd0);
    end

    // single byte
    r0 = rinc_n; o0 = oe_n; w0 = wrlow_n;
    rst = 1'b0;
    repeat (20) tick();
    chk("single_pops", r0 == 0 ? rinc_n : rinc_n - r0, 32'd1);
    chk("single_oe_cycles", oe_n - o0, 32'd4);
    chk("single_wr_low", wrlow_n - w0, 32'd2);
    chk("single_strobes", strobe_dat.size(), 32'd1);
    if (strobe_dat.size() > 0) chk("single_data", strobe_dat[0], 8'hA5);
    chk("single_count", byte_count, 32'd1);
    chk("single_empty", fifo_rempty, 1'b1);
    chk("single_idle", busy, 1'b0);

    // burst of four
    s0 = strobe_dat.size(); r0 = rinc_n;
    for (int i = 0; i < 4; i++) push(burst[i]);
    repeat (40) tick();
    chk("burst_strobes", strobe_dat.size() - s0, 32'd4);
    chk("burst_pops", rinc_n - r0, 32'd4);
    if (strobe_dat.size() >= s0 + 4) begin
      for (int i = 0; i < 4; i++) chk("burst_data", strobe_dat[s0 + i], burst[i]);
      for (int i = 1; i < 4; i++) chk("burst_spacing", strobe_cyc[s0 + i] - strobe_cyc[s0 + i - 1], 32'd8);
    end
    chk("burst_count", byte_count, 32'd5);
    chk("burst_empty", fifo_rempty, 1'b1);

    // tx_en dropped during the strobe of 0x02
    for (int i = 0; i < 4; i++) push(burst[i]);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (ft_wr_n == 1'b0 && ft_data == 8'h02) found = 1'b1;
    end
    chk("txen_strobe02_seen", found, 1'b1);
    tx_en = 1'b0;
    r0 = rinc_n;
    repeat (30) tick();
    chk("txen_count", byte_count, 32'd7);
    chk("txen_no_pop", rinc_n - r0, 32'd0);
    chk("txen_left", exp_q.size(), 32'd2);
    chk("txen_last", strobe_dat[strobe_dat.size() - 1], 8'h02);
    tx_en = 1'b1;
    repeat (30) tick();
    chk("resume_count", byte_count, 32'd9);
    chk("resume_empty", fifo_rempty, 1'b1);
    chk("resume_d0", strobe_dat[strobe_dat.size() - 2], 8'h0A);
    chk("resume_d1", strobe_dat[strobe_dat.size() - 1], 8'h0B);

    // flow control via TXE#
    ft_txe_n = 1'b1;
    repeat (3) tick();
    push(8'h55);
    r0 = rinc_n; w0 = wrlow_n;
    repeat (20) tick();
    chk("flow_no_pop", rinc_n - r0, 32'd0);
    chk("flow_no_strobe", wrlow_n - w0, 32'd0);
    ft_txe_n = 1'b0;
    found = 1'b0; lat = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      lat++;
      if (fifo_rinc) found = 1'b1;
    end
    chk("flow_started", found, 1'b1);
    chk("flow_latency", lat, 32'd3);
    repeat (10) tick();
    chk("flow_data", strobe_dat[strobe_dat.size() - 1], 8'h55);
    chk("flow_count", byte_count, 32'd10);

    // reset in the middle of a strobe
    push(8'h77);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (ft_wr_n == 1'b0) found = 1'b1;
    end
    chk("midrst_strobe_seen", found, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_wr_n", ft_wr_n, 1'b1);
    chk("midrst_oe", ft_data_oe, 1'b0);
    chk("midrst_count", byte_count, 32'd0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (12) tick();
    chk("post_rst_count", byte_count, 32'd0);
    chk("post_rst_idle", busy, 1'b0);
    chk("post_rst_empty", fifo_rempty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
